sprite_frame_loader: RTL
========================

// Module: sprite_frame_loader
// PURPOSE
//   Double-buffered sprite bitmap store between the CORDIC sprite rotator and the
//   frame-buffer display compositor. Each frame it requests a fresh rotated sprite,
//   captures its rows into a back bank, and swaps banks at frame start.
//   The compositor reads a stable front bank by row index while the back bank fills.
// PARAMETERS
//   SPR_W   57  sprite row width in pixels (bits per row)
//   SPR_H   57  sprite height in rows
//   IDX_W   10  width of rotator row-index bus
// PORTS
//   pixelCLK     in   1       pixel clock; single clock domain
//   RST_N        in   1       asynchronous reset, active low
//   frame_start  in   1       1-cycle pulse at HCount==0 && VCount==0
//   rot_start    out  1       1-cycle request pulse to rotator (starts a new sprite)
//   in_valid     in   1       rotator row valid
//   in_row       in   IDX_W   row index of in_data
//   in_data      in   SPR_W   rotated sprite row, bit 0 = leftmost pixel
//   rd_row       in   6       compositor read row index
//   rd_data      out  SPR_W   front-bank row, registered
//   mirror       in   1       horizontal mirror request (used only with SPRITE_MIRROR_EN)
//   front_valid  out  1       front bank holds a complete sprite
//   overrun      out  1       sticky: frame_start arrived before fill completed
// BEHAVIOUR
//   Reset: rot_start=0, rd_data=0, front_valid=0, overrun=0, front bank=0,
//     row mask cleared, FSM=IDLE. Bank contents are not reset.
//   FSM: IDLE -> REQ on first cycle after reset release.
//     REQ: rot_start=1 for exactly one cycle; clear row mask; -> FILL.
//     FILL: on in_valid && in_row<SPR_H write in_data to back[in_row], set mask bit;
//       in_row>=SPR_H is dropped (absorbs rotator index skew). Rewrites overwrite.
//       When all SPR_H mask bits are set -> READY (the cycle after the last write).
//     READY: ignore in_valid; on frame_start toggle front bank, front_valid<=1, -> REQ.
//   frame_start during REQ/FILL: no swap, overrun<=1 (sticky until reset); fill
//     continues; swap happens on first frame_start after READY.
//   frame_start and last row write in the same cycle: write is taken, no swap this
//     frame, overrun set.
//   Read: rd_data <= (front_valid && rd_row<SPR_H) ? front[rd_row] : 0; latency 1 cycle.
//     Bank swap is visible to a read issued the cycle after frame_start.
//   Read and write never target the same bank; no bypass path.
//   RST_N asserted mid-fill: fill abandoned, FSM returns to IDLE, front_valid=0.
// CONFIGURATION
//   SPRITE_MIRROR_EN defined: when mirror=1, rd_data bit i = row bit SPR_W-1-i;
//     mirror sampled with rd_row (same cycle).
//   Not defined: mirror port present but ignored; rd_data is never reversed.
// STRUCTURE
//   sprite_pkg: SPR_W, SPR_H, IDX_W defaults; FSM state enum {IDLE,REQ,FILL,READY}.
//   Sub-module sprite_row_bank: SPR_H x SPR_W storage, 1 write port, 1 registered
//     read port; instantiated twice, bank select muxes in top.
// TESTING
//   Reset release -> rot_start high exactly one cycle 1 clk after RST_N rises;
//     rd_data=0, front_valid=0 for any rd_row.
//   Feed rows 0..56 with in_data=row number, then frame_start -> front_valid=1;
//     rd_row=5 gives rd_data=57'd5 next cycle; rot_start pulses again.
//   Rows with in_row=57,500 interleaved -> ignored; fill still completes on 57 valid rows.
//   frame_start after only 30 rows -> overrun=1, front bank unchanged; finish rows,
//     next frame_start swaps.
//   rd_row=60 with valid front -> rd_data=0.
//   SPRITE_MIRROR_EN, row 3 = 57'h1, mirror=1 -> rd_data = 57'h1<<56; undefined -> 57'h1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared widths, FSM state type and row helper for the sprite frame loader.
// Optional horizontal mirroring on the read path is enabled by SPRITE_MIRROR_EN.
package sprite_pkg;

    localparam int SPR_W  = 57;
    localparam int SPR_H  = 57;
    localparam int IDX_W  = 10;
    localparam int ROW_AW = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        READY
    } state_t;

    typedef logic [SPR_W-1:0] row_t;

    // Bit 0 is the leftmost pixel, so mirroring is a plain bit reversal.
    function automatic row_t reverse_row(input row_t r);
        row_t out;
        for (int i = 0; i < SPR_W; i++) begin
            out[i] = r[SPR_W-1-i];
        end
        return out;
    endfunction

endpackage

// File: rtl/sprite_frame_loader_if.sv
// Rotator-side fill bus, compositor read bus and status flags of the sprite loader.
interface sprite_frame_loader_if;
    import sprite_pkg::*;

    logic               frame_start;
    logic               rot_start;
    logic               in_valid;
    logic [IDX_W-1:0]   in_row;
    row_t               in_data;
    logic [ROW_AW-1:0]  rd_row;
    row_t               rd_data;
    logic               mirror;
    logic               front_valid;
    logic               overrun;

    modport master (
        output frame_start, in_valid, in_row, in_data, rd_row, mirror,
        input  rot_start, rd_data, front_valid, overrun
    );

    modport slave (
        input  frame_start, in_valid, in_row, in_data, rd_row, mirror,
        output rot_start, rd_data, front_valid, overrun
    );

endinterface

// File: rtl/sprite_row_bank.sv
// One SPR_H x SPR_W sprite bitmap bank with a write port and a registered read port.
module sprite_row_bank
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ROW_AW-1:0] waddr,
    input  row_t              wdata,
    input  logic [ROW_AW-1:0] raddr,
    output row_t              rdata
);

    localparam logic [ROW_AW-1:0] H_ROW = ROW_AW'(SPR_H);

    row_t mem_q [SPR_H];
    row_t rdata_q;
    row_t rdata_d;

    always_comb begin
        rdata_d = '0;
        if (raddr < H_ROW) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage is deliberately unreset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_frame_loader.sv
// Double-buffered sprite store: fills a back bank from the rotator, swaps at frame start.
// Define SPRITE_MIRROR_EN to honour the mirror input on the read path.
module sprite_frame_loader
    import sprite_pkg::*;
(
    input  logic                  pixelCLK,
    input  logic                  RST_N,
    sprite_frame_loader_if.slave  sif
);

    localparam logic [IDX_W-1:0]  H_IDX = IDX_W'(SPR_H);
    localparam logic [ROW_AW-1:0] H_ROW = ROW_AW'(SPR_H);

    state_t             state_q, state_d;
    logic [SPR_H-1:0]   mask_q, mask_d;
    logic               front_sel_q, front_sel_d;
    logic               front_valid_q, front_valid_d;
    logic               overrun_q, overrun_d;
    logic               rd_ok_q, rd_ok_d;
    logic               rd_sel_q, rd_sel_d;
    logic               mirror_q, mirror_d;

    logic               wr_en;
    logic               swap;
    logic               rot_start;
    logic [ROW_AW-1:0]  wr_addr;
    row_t               bank0_rdata, bank1_rdata;
    row_t               front_row;
    row_t               rd_data;

    assign wr_addr = sif.in_row[ROW_AW-1:0];

`ifdef SPRITE_MIRROR_EN
    assign mirror_d = sif.mirror;
`else
    logic unused_mirror;
    assign unused_mirror = sif.mirror;
    assign mirror_d      = 1'b0;
`endif

    always_ff @(posedge pixelCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pixelCLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_q        <= '0;
            front_sel_q   <= 1'b0;
            front_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            rd_ok_q       <= 1'b0;
            rd_sel_q      <= 1'b0;
            mirror_q      <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            front_sel_q   <= front_sel_d;
            front_valid_q <= front_valid_d;
            overrun_q     <= overrun_d;
            rd_ok_q       <= rd_ok_d;
            rd_sel_q      <= rd_sel_d;
            mirror_q      <= mirror_d;
        end
    end

    // Out-of-range row indices from the rotator are silently dropped.
    always_comb begin
        wr_en  = (state_q == FILL) && sif.in_valid && (sif.in_row < H_IDX);
        swap   = (state_q == READY) && sif.frame_start;
        mask_d = mask_q;
        if (state_q == REQ) begin
            mask_d = '0;
        end else if (wr_en) begin
            mask_d[wr_addr] = 1'b1;
        end
        front_sel_d   = front_sel_q ^ swap;
        front_valid_d = front_valid_q | swap;
        overrun_d     = overrun_q | (sif.frame_start && ((state_q == REQ) || (state_q == FILL)));
        rd_ok_d       = front_valid_q && (sif.rd_row < H_ROW);
        rd_sel_d      = front_sel_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = FILL;
            FILL:    if (&mask_d) state_d = READY;
            READY:   if (swap) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rot_start = (state_q == REQ);
        front_row = rd_sel_q ? bank1_rdata : bank0_rdata;
        rd_data   = '0;
        if (rd_ok_q) begin
            rd_data = mirror_q ? reverse_row(front_row) : front_row;
        end
    end

    // The back bank is always the one the front select is not pointing at.
    sprite_row_bank u_bank0 (
        .clk   (pixelCLK),
        .we    (wr_en && front_sel_q),
        .waddr (wr_addr),
        .wdata (sif.in_data),
        .raddr (sif.rd_row),
        .rdata (bank0_rdata)
    );

    sprite_row_bank u_bank1 (
        .clk   (pixelCLK),
        .we    (wr_en && !front_sel_q),
        .waddr (wr_addr),
        .wdata (sif.in_data),
        .raddr (sif.rd_row),
        .rdata (bank1_rdata)
    );

    assign sif.rot_start   = rot_start;
    assign sif.rd_data     = rd_data;
    assign sif.front_valid = front_valid_q;
    assign sif.overrun     = overrun_q;

endmodule
